// File: rtl/hdlc_rx_drain.sv
// rtl/hdlc_rx_drain.sv - autonomous HDLC Rx controller: polls Rx_SC, streams good frames, drops bad ones
module hdlc_rx_drain #(
  parameter int POLL_INTERVAL = 16,
  parameter int FCS_EN        = 1,
  parameter int MAX_FRAME     = 126
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  output logic [2:0]  address_o,
  output logic        write_enable_o,
  output logic        read_enable_o,
  output logic [7:0]  data_in_o,
  input  logic [7:0]  data_out_i,
  output logic [7:0]  m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        m_last_o,
  output logic        m_err_o,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] drop_cnt_o
);

  typedef enum logic [3:0] {
    S_CFG, S_WAIT, S_POLL_RD, S_POLL_CHK, S_LEN_RD,
    S_LEN_CHK, S_BYTE_RD, S_BYTE_CHK, S_OUT, S_DROP
  } state_e;

  localparam logic        FCS_BIT   = (FCS_EN != 0);
  localparam logic [7:0]  CFG_WORD  = {2'b00, FCS_BIT, 5'b00000};
  localparam logic [7:0]  DROP_WORD = {2'b00, FCS_BIT, 3'b000, 1'b1, 1'b0};
  localparam logic [15:0] WAIT_LOAD = 16'(POLL_INTERVAL - 1);
  localparam logic [7:0]  MAX_LEN   = 8'(MAX_FRAME);
  localparam logic [2:0]  A_SC      = 3'd2;
  localparam logic [2:0]  A_BUFF    = 3'd3;
  localparam logic [2:0]  A_LEN     = 3'd4;

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic [7:0]  rem_q, rem_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic [7:0]  din_q, din_d;
  logic [7:0]  mdata_q, mdata_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] drop_q, drop_d;

  // State and registered bus/stream outputs; bus strobes are set on entry to the owning state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_CFG;
      wait_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      din_q   <= '0;
      mdata_q <= '0;
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      re_q    <= re_d;
      din_q   <= din_d;
      mdata_q <= mdata_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic; strobes default low so each lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    din_d   = din_q;
    mdata_d = mdata_q;
    frame_d = frame_q;
    drop_d  = drop_q;
    case (state_q)
      S_CFG: begin
        we_d    = 1'b1;
        addr_d  = A_SC;
        din_d   = CFG_WORD;
        wait_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q != 16'd0) begin
          wait_d = wait_q - 16'd1;
        end else if (enable_i) begin
          re_d    = 1'b1;
          addr_d  = A_SC;
          state_d = S_POLL_RD;
        end
      end
      S_POLL_RD: state_d = S_POLL_CHK;
      S_POLL_CHK: begin
        if (data_out_i[0]) begin
          ovf_d   = data_out_i[4];
          re_d    = 1'b1;
          addr_d  = A_LEN;
          state_d = S_LEN_RD;
        end else if (data_out_i[2] | data_out_i[3]) begin
          we_d    = 1'b1;
          addr_d  = A_SC;
          din_d   = DROP_WORD;
          state_d = S_DROP;
        end else begin
          wait_d  = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_LEN_RD: state_d = S_LEN_CHK;
      S_LEN_CHK: begin
        rem_d = data_out_i;
        if ((data_out_i == 8'd0) || (data_out_i > MAX_LEN)) begin
          we_d    = 1'b1;
          addr_d  = A_SC;
          din_d   = DROP_WORD;
          state_d = S_DROP;
        end else begin
          re_d    = 1'b1;
          addr_d  = A_BUFF;
          state_d = S_BYTE_RD;
        end
      end
      S_BYTE_RD: state_d = S_BYTE_CHK;
      S_BYTE_CHK: begin
        mdata_d = data_out_i;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (m_ready_i) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            frame_d = frame_q + 16'd1;
            wait_d  = WAIT_LOAD;
            state_d = S_WAIT;
          end else begin
            re_d    = 1'b1;
            addr_d  = A_BUFF;
            state_d = S_BYTE_RD;
          end
        end
      end
      S_DROP: begin
        drop_d  = drop_q + 16'd1;
        wait_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end
      default: state_d = S_CFG;
    endcase
  end

  assign address_o      = addr_q;
  assign write_enable_o = we_q;
  assign read_enable_o  = re_q;
  assign data_in_o      = din_q;
  assign m_data_o       = mdata_q;
  assign m_valid_o      = (state_q == S_OUT);
  assign m_last_o       = m_valid_o & (rem_q == 8'd1);
  assign m_err_o        = m_last_o & ovf_q;
  assign frame_cnt_o    = frame_q;
  assign drop_cnt_o     = drop_q;

endmodule

// File: tb/tb_hdlc_rx_drain.sv
// tb/tb_hdlc_rx_drain.sv - scoreboard bench for hdlc_rx_drain with a behavioural HDLC register model
module tb_hdlc_rx_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        m_ready = 1'b1;
  logic [7:0]  data_out = 8'h00;
  logic [2:0]  address;
  logic        we, re;
  logic [7:0]  din, m_data;
  logic        m_valid, m_last, m_err;
  logic [15:0] frame_cnt, drop_cnt;

  hdlc_rx_drain #(.POLL_INTERVAL(16), .FCS_EN(1), .MAX_FRAME(126)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .address_o(address), .write_enable_o(we), .read_enable_o(re),
    .data_in_o(din), .data_out_i(data_out),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_last_o(m_last), .m_err_o(m_err),
    .frame_cnt_o(frame_cnt), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboards: stream bytes {err,last,data} and bus writes {addr,data}
  logic [9:0]  exp_q[$];
  logic [10:0] exp_wr[$];
  int          fires[$];

  // Core model state (owned by the monitor) and load requests from the stimulus
  logic [7:0]  rx_sc = 8'h00, rx_len = 8'h00;
  logic [7:0]  buff[$];
  logic [7:0]  ld_sc, ld_len;
  logic [7:0]  ld_bytes[$];
  int          ld_req = 0, ld_seen = 0;
  int          re_count = 0;
  int          wr_cyc = -1, first_re_cyc = -1;
  logic        prev_re = 1'b0, prev_we = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // HDLC core model and output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (ld_req != ld_seen) begin
      ld_seen = ld_req;
      rx_sc   = ld_sc;
      rx_len  = ld_len;
      buff    = ld_bytes;
    end
    if (rst_n) begin
      if (re && we) check("re_we_excl", 1, 0);
      if (re && prev_re) check("re_one_cycle", 1, 0);
      if (we && prev_we) check("we_one_cycle", 1, 0);
      if (we) begin
        if (wr_cyc < 0) wr_cyc = cyc;
        if (exp_wr.size() == 0) check("unexp_write", {address, din}, 0);
        else begin
          logic [10:0] w;
          w = exp_wr.pop_front();
          check("wr_addr", address, w[10:8]);
          check("wr_data", din, w[7:0]);
        end
        if (address == 3'd2 && din[1]) begin
          rx_sc = 8'h00;
          buff.delete();
        end
      end
      if (re) begin
        re_count++;
        if (first_re_cyc < 0) first_re_cyc = cyc;
        case (address)
          3'd2: data_out = rx_sc;
          3'd4: data_out = rx_len;
          3'd3: begin
            if (buff.size() > 0) data_out = buff.pop_front();
            else data_out = 8'h00;
            if (buff.size() == 0) rx_sc = 8'h00;
          end
          default: data_out = 8'h00;
        endcase
      end
      if (m_valid && m_ready) begin
        fires.push_back(cyc);
        if (exp_q.size() == 0) check("unexp_byte", {m_err, m_last, m_data}, 0);
        else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("m_data", m_data, e[7:0]);
          check("m_last", m_last, e[8]);
          check("m_err", m_err, e[9]);
        end
      end
      prev_re = re;
      prev_we = we;
    end
  end

  task automatic load_frame(input logic [7:0] sc, input logic [7:0] len,
                            input logic [7:0] bytes[$], input bit good);
    ld_bytes = bytes;
    if (good)
      for (int i = 0; i < bytes.size(); i++)
        exp_q.push_back({sc[4] && (i == bytes.size() - 1), i == bytes.size() - 1, bytes[i]});
    else
      exp_wr.push_back({3'd2, 8'h22});
    fires.delete();
    ld_sc  = sc;
    ld_len = len;
    ld_req++;
  endtask

  task automatic wait_done(input logic [15:0] f0, input logic [15:0] d0, input bit good, input string tag);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (frame_cnt != f0 || drop_cnt != d0) break;
    end
    if (k == 2000) check({tag, "_timeout"}, 1, 0);
    if (good) check({tag, "_frame_cnt"}, frame_cnt, f0 + 16'd1);
    else      check({tag, "_drop_cnt"}, drop_cnt, d0 + 16'd1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic run_frame(input logic [7:0] sc, input logic [7:0] len,
                           input logic [7:0] bytes[$], input bit good, input string tag);
    logic [15:0] f0, d0;
    f0 = frame_cnt;
    d0 = drop_cnt;
    load_frame(sc, len, bytes, good);
    wait_done(f0, d0, good, tag);
  endtask

  logic [7:0] q[$];
  logic [7:0] none[$];

  initial begin
    logic [15:0] f0, d0;
    int k, r0;
    exp_wr.push_back({3'd2, 8'h20});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus", {address, we, re, din}, 0);
    check("rst_stream", {m_data, m_valid, m_last, m_err}, 0);
    check("rst_cnt", {frame_cnt, drop_cnt}, 0);
    rst_n = 1'b1;

    for (k = 0; k < 100 && first_re_cyc < 0; k++) @(negedge clk);
    check("cfg_written", exp_wr.size(), 0);
    check("first_poll_gap", first_re_cyc - wr_cyc, 16);

    // Good frame, ready held high
    q = '{8'hA1, 8'hB2, 8'hC3};
    run_frame(8'h21, 8'd3, q, 1'b1, "good");
    check("good_gap1", fires[1] - fires[0], 3);
    check("good_gap2", fires[2] - fires[1], 3);

    // Backpressure on byte 2
    f0 = frame_cnt;
    d0 = drop_cnt;
    load_frame(8'h21, 8'd3, q, 1'b1);
    for (k = 0; k < 200 && fires.size() < 1; k++) @(posedge clk);
    #1 m_ready = 1'b0;
    r0 = re_count;
    for (k = 0; k < 20 && !m_valid; k++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", {m_valid, m_data}, {1'b1, 8'hB2});
      @(posedge clk);
      #1;
    end
    check("bp_no_extra_read", re_count - r0, 1);
    m_ready = 1'b1;
    wait_done(f0, d0, 1'b1, "bp");
    check("bp_gap", fires[1] - fires[0], 8);

    // Abort and frame error
    run_frame(8'h28, 8'd0, none, 1'b0, "abort");
    run_frame(8'h24, 8'd0, none, 1'b0, "ferr");
    check("drop_total", drop_cnt, 2);

    // Length limits
    run_frame(8'h21, 8'd0, none, 1'b0, "len0");
    run_frame(8'h21, 8'd127, none, 1'b0, "len127");
    q.delete();
    for (int i = 0; i < 126; i++) q.push_back(8'($urandom));
    run_frame(8'h21, 8'd126, q, 1'b1, "len126");
    check("len126_bytes", fires.size(), 126);

    // Overflow flag on last byte
    q = '{8'h5A, 8'hA5};
    run_frame(8'h31, 8'd2, q, 1'b1, "ovf");

    // Reset in the middle of a frame, then the same frame re-polled
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    load_frame(8'h21, 8'd5, q, 1'b1);
    for (k = 0; k < 200 && fires.size() < 2; k++) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_bus", {address, we, re, din}, 0);
    check("midrst_stream", {m_data, m_valid, m_last, m_err}, 0);
    check("midrst_cnt", {frame_cnt, drop_cnt}, 0);
    exp_q.delete();
    exp_wr.delete();
    exp_wr.push_back({3'd2, 8'h20});
    load_frame(8'h21, 8'd5, q, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done(16'd0, 16'd0, 1'b1, "after_rst");
    check("after_rst_cfg", exp_wr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hdlc_rx_drain.md
# hdlc_rx_drain

Autonomous Rx-side controller for the HDLC core. It sits on the HDLC register bus in place of a host CPU. After reset it configures the receiver, then polls Rx_SC. Each good frame is read out of Rx_Buff byte by byte and streamed downstream over a valid/ready handshake. Errored, aborted and over-length frames are dropped through the Rx_SC drop bit and counted.

## Interface
- POLL_INTERVAL, 16: idle cycles between Rx_SC polls (≥1).
- FCS_EN, 1: value written to Rx_SC bit5 (Rx_FCSen) at configure and on every drop write.
- MAX_FRAME, 126: largest accepted Rx_Len; above this the frame is dropped as an error.
- Clk  in  1  system clock, all logic on posedge.
- Rst  in  1  asynchronous, active-low reset.
- Enable  in  1  when 0, no new poll starts; a frame in progress completes.
- Address  out  3  register address (2 = Rx_SC, 3 = Rx_Buff, 4 = Rx_Len).
- WriteEnable  out  1  one-cycle write strobe.
- ReadEnable  out  1  one-cycle read strobe.
- DataIn  out  8  write data to the HDLC core.
- DataOut  in  8  read data, valid the cycle after ReadEnable.
- M_Data  out  8  frame byte.
- M_Valid  out  1  M_Data valid; held until accepted.
- M_Ready  in  1  downstream accept.
- M_Last  out  1  qualifies the final byte of a frame.
- M_Err  out  1  on the last byte, marks that Rx_Overflow was set for the frame.
- FrameCnt  out  16  frames streamed, wraps.
- DropCnt  out  16  frames dropped, wraps.

## Operation
- Rx_SC bit map: 0 Rx_Ready, 1 Rx_Drop, 2 Rx_FrameError, 3 Rx_AbortSignal, 4 Rx_Overflow, 5 Rx_FCSen.
- States: CFG, WAIT, POLL_RD, POLL_CHK, LEN_RD, LEN_CHK, BYTE_RD, BYTE_CHK, OUT, DROP.
- CFG: one cycle after reset release. Write Address=2, DataIn={2'b0,FCS_EN,5'b0}, then go to WAIT.
- WAIT: a counter loads POLL_INTERVAL-1 on entry and decrements to 0. Go to POLL_RD at 0 if Enable=1, otherwise stay.
- POLL_RD: ReadEnable with Address=2. POLL_CHK samples DataOut:
  - bit0=1 goes to LEN_RD and latches bit4 as the overflow flag.
  - Else bit2|bit3=1 goes to DROP.
  - Else back to WAIT.
- LEN_RD: ReadEnable with Address=4. LEN_CHK latches DataOut into the remaining counter:
  - 0 or >MAX_FRAME goes to DROP.
  - Otherwise go to BYTE_RD.
- BYTE_RD: ReadEnable with Address=3. BYTE_CHK latches DataOut into M_Data and goes to OUT.
- OUT: M_Valid=1. M_Last=1 when remaining==1. M_Err=M_Last&overflow flag. On M_Valid&M_Ready, decrement remaining:
  - If the new value is 0, FrameCnt++ and go to WAIT.
  - Otherwise go to BYTE_RD.
- DROP: write Address=2, DataIn={2'b0,FCS_EN,3'b0,1'b1,1'b0}. DropCnt++ and go to WAIT.
- ReadEnable and WriteEnable are mutually exclusive and never held for more than one cycle.
- Address holds its last value when no strobe is active.

## Timing
- Reset values: state CFG, Address 0, WriteEnable 0, ReadEnable 0, DataIn 0, M_Data 0, M_Valid 0, M_Last 0, M_Err 0, FrameCnt 0, DropCnt 0, counters 0.
- Latency:
  - Poll strobe to decision: 2 cycles.
  - Per byte with M_Ready held high: 3 cycles (BYTE_RD, BYTE_CHK, OUT). Throughput is 1 byte per 3 cycles.
- M_Data, M_Last and M_Err are stable while M_Valid=1 and M_Ready=0.
- Enable falling during LEN_RD..OUT has no effect until the return to WAIT.
- Reset assertion mid-frame aborts immediately and outputs go to their reset values. The HDLC core's pending frame is re-polled after CFG.
- Counter wrap: 16'hFFFF+1 → 0, with no saturation.
- All registers update on posedge Clk. The only asynchronous path is Rst.

## Test plan
- Reset and configure: release Rst → exactly one write with Address=2 and DataIn=0x20 (FCS_EN=1), then the first ReadEnable at Address=2 comes POLL_INTERVAL cycles later.
- Good frame: Rx_SC=0x21, Rx_Len=3, bytes A1,B2,C3, M_Ready=1 → M_Data A1,B2,C3 at a 3-cycle spacing, M_Last only on C3, M_Err=0, FrameCnt=1.
- Backpressure: same frame with M_Ready low for 5 cycles on byte 2 → B2 held stable for 6 cycles, no extra ReadEnable issued, all bytes delivered in order.
- Abort/FCS error: Rx_SC=0x28 (abort), then 0x24 (frame error) → two drop writes with DataIn=0x22, DropCnt=2, no M_Valid.
- Length limits: Rx_Len=0 and Rx_Len=127 → both dropped. Rx_Len=126 → 126 bytes streamed.
- Overflow and reset: Rx_SC=0x31, Rx_Len=2 → second byte has M_Last=1 and M_Err=1. Then assert Rst mid-frame → outputs are 0 immediately and the sequence restarts from CFG.
